// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio sample fetch path.
package audio_pkg;

    localparam int          SAMPLE_W          = 16;
    localparam int          AUDIO_NUM_SAMPLES = 112000;
    localparam logic [31:0] AUDIO_BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] AUDIO_ADDR_STRIDE = 32'd4;

    typedef logic [15:0] sample_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN,
        FETCH_DONE
    } fetch_state_e;

endpackage

// File: rtl/sample_skid_fifo.sv
// Two-entry FIFO that absorbs the ROM read latency; push and pop may coincide when full.
module sample_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/audio_sample_fetcher.sv
// Sequential ROM sample fetcher feeding a valid/ready stream through a 2-entry FIFO.
// Define SAMPLE_FETCH_LOOP_EN for gapless looped playback (only stop or rst exits).
module audio_sample_fetcher #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          NUM_SAMPLES = 112000,
    parameter logic [31:0] ADDR_STRIDE = 32'd4,
    parameter int          SAMPLE_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic [31:0]             mem_addr,
    input  logic [SAMPLE_W-1:0]     mem_rd,
    output logic [SAMPLE_W-1:0]     sample_data,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    busy,
    output logic                    done,
    output audio_pkg::fetch_state_e dbg_state
);
    import audio_pkg::*;

    localparam int               CNT_W   = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(NUM_SAMPLES - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      mem_addr_q;
    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] pop_cnt_q;
    logic             inflight_q;
    logic             done_q;

    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop, issue, last_issue, final_pop, start_ok, space_ok;

    // Stream handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
    // once sample_valid rises, it and sample_data hold until that transfer, stop or rst.
    assign sample_valid = !fifo_empty;
    assign pop          = sample_valid && sample_ready;
    assign start_ok     = start && ((state_q == FETCH_IDLE) || (state_q == FETCH_DONE));
    assign final_pop    = pop && (pop_cnt_q == LAST_M1);
    assign issue        = (state_q == FETCH_RUN) && (issue_cnt_q != LAST) && space_ok;
    assign last_issue   = issue && (issue_cnt_q == LAST_M1);

    // Reads are un-stallable, so an issue needs room for its data after this cycle's pop.
    always_comb begin
        space_ok = 1'b0;
        if (fifo_full) begin
            space_ok = pop;
        end else begin
            space_ok = (({1'b0, fifo_count} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: begin
                if (start_ok) state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
`ifdef SAMPLE_FETCH_LOOP_EN
                state_d = FETCH_RUN;
`else
                if (last_issue) state_d = FETCH_DRAIN;
`endif
            end
            FETCH_DRAIN: begin
                if (final_pop) state_d = FETCH_DONE;
            end
            FETCH_DONE: begin
                state_d = start_ok ? FETCH_RUN : FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (stop) state_d = FETCH_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            mem_addr_q  <= BASE_ADDR;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= final_pop && !stop;
            if (stop) begin
                inflight_q  <= 1'b0;
                issue_cnt_q <= '0;
                pop_cnt_q   <= '0;
            end else begin
                inflight_q <= issue;
                if (start_ok) begin
                    mem_addr_q  <= BASE_ADDR;
                    issue_cnt_q <= '0;
                    pop_cnt_q   <= '0;
                end else begin
                    if (issue) begin
`ifdef SAMPLE_FETCH_LOOP_EN
                        if (last_issue) begin
                            mem_addr_q  <= BASE_ADDR;
                            issue_cnt_q <= '0;
                        end else begin
                            mem_addr_q  <= mem_addr_q + ADDR_STRIDE;
                            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        end
`else
                        mem_addr_q  <= mem_addr_q + ADDR_STRIDE;
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
`endif
                    end
                    if (pop) begin
                        pop_cnt_q <= final_pop ? '0 : pop_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    sample_skid_fifo #(.W(SAMPLE_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (stop),
        .push      (inflight_q),
        .push_data (mem_rd),
        .pop       (pop),
        .head      (sample_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_addr  = mem_addr_q;
    assign busy      = (state_q == FETCH_RUN) || (state_q == FETCH_DRAIN);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Bench for audio_sample_fetcher: behavioural stream model plus directed and random passes.
module tb_audio_sample_fetcher;
    import audio_pkg::*;

    localparam logic [31:0] BASE   = 32'h0;
    localparam logic [31:0] STRIDE = 32'd4;
`ifdef SAMPLE_FETCH_LOOP_EN
    localparam int N = 4;
`else
    localparam int N = 8;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                sample_ready = 1'b1;
    logic [31:0]         mem_addr;
    logic [SAMPLE_W-1:0] mem_rd = '0;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                busy;
    logic                done;
    fetch_state_e        dbg_state;

    audio_sample_fetcher #(
        .BASE_ADDR   (BASE),
        .NUM_SAMPLES (N),
        .ADDR_STRIDE (STRIDE),
        .SAMPLE_W    (SAMPLE_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / ROM ----------------
    always #5 clk = ~clk;

    function automatic sample_t rom_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        return idx[15:0] + 16'h0100;
    endfunction

    always @(posedge clk) mem_rd <= rom_word(mem_addr);

    // ---------------- ready driver ----------------
    logic ready_mode  = 1'b0;
    logic ready_force = 1'b1;

    always @(posedge clk) begin
        #2;
        if (ready_mode) sample_ready = ($urandom_range(0, 1) == 1);
        else            sample_ready = ready_force;
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [SAMPLE_W-1:0] exp_q[$];
    logic [SAMPLE_W-1:0] got_q[$];
    logic [SAMPLE_W-1:0] exp_s;
    logic [SAMPLE_W-1:0] prev_data;
    logic [31:0]         prev_addr = BASE;
    logic m_busy = 1'b0, m_done_exp = 1'b0, nxt_busy, nxt_done;
    logic m_after_start = 1'b0, m_after_stop = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_stop = 1'b0;
    int   m_steps = 0, m_acc = 0;
    int   cyc = 0, done_cnt = 0;
    int   pass_start_cyc = 0, first_valid_cyc = -1;
    int   acc_first_cyc = 0, acc_last_cyc = 0;

    task automatic fill_pass();
        for (int i = 0; i < N; i++) exp_q.push_back(sample_t'(i + 32'h100));
    endtask

    function automatic logic [31:0] step_addr(input logic [31:0] a);
`ifdef SAMPLE_FETCH_LOOP_EN
        return (a + STRIDE == BASE + STRIDE * N) ? BASE : a + STRIDE;
`else
        return a + STRIDE;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done_exp = 1'b0; exp_q.delete();
            m_steps = 0; m_acc = 0; prev_addr = BASE;
            prev_valid = 1'b0; prev_stop = 1'b0;
            m_after_start = 1'b0; m_after_stop = 1'b0;
        end else begin
            cyc++;
            if (done) done_cnt++;
            check("busy", busy, m_busy);
            check("done", done, m_done_exp);
            if (m_after_stop) check("valid_after_stop", sample_valid, 0);
            if (m_after_start) begin
                check("addr_at_start", mem_addr, BASE);
            end else if (mem_addr != prev_addr) begin
                check("addr_step", mem_addr, step_addr(prev_addr));
                m_steps++;
`ifndef SAMPLE_FETCH_LOOP_EN
                check("issue_bound", m_steps <= N, 1);
`endif
            end
            check("outstanding_le2", (m_steps - m_acc) <= 2, 1);
            if (prev_valid && !prev_ready && !prev_stop) begin
                check("hold_valid", sample_valid, 1);
                check("hold_data", sample_data, prev_data);
            end
            if (sample_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

            nxt_busy = m_busy;
            nxt_done = 1'b0;
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("sample_expected", exp_q.size(), 1);
                end else begin
                    exp_s = exp_q.pop_front();
                    check("sample", sample_data, exp_s);
                    if (got_q.size() == 0) acc_first_cyc = cyc;
                    acc_last_cyc = cyc;
                    got_q.push_back(sample_data);
                    m_acc++;
                    if (exp_q.size() == 0) begin
                        nxt_done = 1'b1;
`ifdef SAMPLE_FETCH_LOOP_EN
                        fill_pass();
`else
                        nxt_busy = 1'b0;
`endif
                    end
                end
            end

            m_after_start = 1'b0;
            m_after_stop  = 1'b0;
            if (stop) begin
                nxt_busy = 1'b0; nxt_done = 1'b0; exp_q.delete();
                m_steps = 0; m_acc = 0; m_after_stop = 1'b1;
            end else if (start && !m_busy) begin
                nxt_busy = 1'b1; exp_q.delete(); fill_pass();
                m_steps = 0; m_acc = 0; m_after_start = 1'b1;
                pass_start_cyc = cyc; first_valid_cyc = -1;
            end
            m_busy     = nxt_busy;
            m_done_exp = nxt_done;
            prev_valid = sample_valid;
            prev_ready = sample_ready;
            prev_stop  = stop;
            prev_data  = sample_data;
            prev_addr  = mem_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int b;
        b = budget;
        while (done_cnt < target && b > 0) begin
            cycle(1);
            b--;
        end
        check("done_count", done_cnt, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_data"}, sample_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, dbg_state, FETCH_IDLE);
    endtask

    // ---------------- stimulus ----------------
    int base_done;
    int budget;

    initial begin
        #12;
        check_reset_values("por");
        @(negedge clk);
        #2 rst = 1'b0;
        cycle(1);

        // Full-rate pass
        got_q.delete();
        base_done = done_cnt;
        pulse_start();
`ifdef SAMPLE_FETCH_LOOP_EN
        wait_done(base_done + 3, 40);
        pulse_stop();
        check("loop_latency", first_valid_cyc - pass_start_cyc, 3);
        check("loop_no_bubble", acc_last_cyc - acc_first_cyc, got_q.size() - 1);
        check("loop_first", got_q[0], 16'h0100);
        check("loop_wrap", got_q[4], 16'h0100);
        check("loop_third_end", got_q[11], 16'h0103);
`else
        wait_done(base_done + 1, 40);
        cycle(2);
        check("latency", first_valid_cyc - pass_start_cyc, 3);
        check("burst_len", got_q.size(), 8);
        check("consecutive", acc_last_cyc - acc_first_cyc, 7);
        check("first_sample", got_q[0], 16'h0100);
        check("last_sample", got_q[7], 16'h0107);
        check("done_once", done_cnt - base_done, 1);
        check("idle_after_done", dbg_state, FETCH_IDLE);
`endif
        cycle(2);

        // Backpressure: ready low for cycles 4..9 after start
        got_q.delete();
        base_done = done_cnt;
        pulse_start();
        cycle(3);
        ready_force = 1'b0;
        cycle(6);
        ready_force = 1'b1;
`ifdef SAMPLE_FETCH_LOOP_EN
        cycle(10);
        pulse_stop();
        check("bp_loop_seq", got_q[5], 16'h0101);
`else
        wait_done(base_done + 1, 40);
        check("bp_count", got_q.size(), 8);
        check("bp_mid", got_q[3], 16'h0103);
        check("bp_last", got_q[7], 16'h0107);
`endif
        cycle(2);

        // stop in cycle 5, then replay from BASE
        base_done = done_cnt;
        pulse_start();
        cycle(4);
        pulse_stop();
        cycle(1);
        check("stop_no_done", done_cnt, base_done);
        check("stop_state", dbg_state, FETCH_IDLE);
        got_q.delete();
        pulse_start();
        cycle(6);
        check("replay_first", got_q[0], 16'h0100);
        pulse_stop();
        cycle(2);

        // Asynchronous reset mid-pass
        pulse_start();
        cycle(4);
        #2 rst = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        cycle(2);

        // Random ready, random starts while busy, random stop points
        ready_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            pulse_start();
            budget = $urandom_range(4, 60);
            while (budget > 0 && m_busy) begin
                start = ($urandom_range(0, 3) == 0);
                cycle(1);
                budget--;
            end
            start = 1'b0;
            if (m_busy) pulse_stop();
            cycle($urandom_range(1, 3));
        end
        ready_mode = 1'b0;
        cycle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
